// File: rtl/particle_plotter.sv
// Frame-buffer write stage: clears the buffer once per frame, then
// plots a clipped SPRITE x SPRITE square per accepted particle.
module particle_plotter #(
  parameter int          H_RES       = 320,
  parameter int          V_RES       = 180,
  parameter int          ADDR_W      = 16,
  parameter int          SPRITE      = 2,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [15:0]       x_in,
  input  logic [15:0]       y_in,
  input  logic [15:0]       color_in,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [15:0]       fb_data_out,
  output logic              fb_we_out,
  output logic              clear_done_out,
  output logic [15:0]       dropped_count_out
);

  typedef enum logic [1:0] {IDLE, CLEAR, PLOT} state_t;

  localparam int NPIX = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
  localparam logic [2:0] SLAST = 3'(SPRITE - 1);

  state_t state, state_n;
  logic [15:0] px, py, pcol, px_n, py_n, pcol_n;
  logic [2:0] dx, dy, dx_n, dy_n;
  logic pending, pending_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0] data_n, drop_n;
  logic we_n, done_n, start_clr;

  logic in_plot, last_px, on_screen;
  logic [2:0] sdx, sdy;
  logic [16:0] tx, ty;
  logic [ADDR_W-1:0] pix_addr, clr_next;
  logic [15:0] pix_col;

  assign ready_out = rst_in && state == IDLE && !frame_start_in;

  // Offsets shown on the outputs lead the state by one: the pixel
  // computed here is the one registered at the coming edge.
  assign in_plot = state == PLOT;
  assign last_px = dx == SLAST && dy == SLAST;
  assign sdx = (dx == SLAST) ? 3'd0 : dx + 3'd1;
  assign sdy = (dx == SLAST) ? dy + 3'd1 : dy;
  assign tx = in_plot ? {1'b0, px} + {14'd0, sdx} : {1'b0, x_in};
  assign ty = in_plot ? {1'b0, py} + {14'd0, sdy} : {1'b0, y_in};
  assign on_screen = tx < 17'(H_RES) && ty < 17'(V_RES);
  assign pix_addr = ADDR_W'(ty) * ADDR_W'(H_RES) + ADDR_W'(tx);
  assign pix_col = in_plot ? pcol : color_in;
  assign clr_next = fb_addr_out + ADDR_W'(1);

  always_comb begin
    state_n   = state;
    px_n      = px;
    py_n      = py;
    pcol_n    = pcol;
    dx_n      = dx;
    dy_n      = dy;
    pending_n = pending;
    addr_n    = fb_addr_out;
    data_n    = fb_data_out;
    drop_n    = dropped_count_out;
    we_n      = 1'b0;
    done_n    = 1'b0;
    start_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start_in) begin
          start_clr = 1'b1;
        end else if (valid_in) begin
          px_n   = x_in;
          py_n   = y_in;
          pcol_n = color_in;
          if (!on_screen) begin
            if (dropped_count_out != 16'hFFFF)
              drop_n = dropped_count_out + 16'd1;
          end else begin
            state_n = PLOT;
            dx_n    = 3'd0;
            dy_n    = 3'd0;
            we_n    = 1'b1;
            addr_n  = pix_addr;
            data_n  = pix_col;
          end
        end
      end
      CLEAR: begin
        if (frame_start_in) begin
          start_clr = 1'b1;
        end else if (fb_addr_out == LAST) begin
          state_n = IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = clr_next;
          data_n = CLEAR_COLOR;
          done_n = clr_next == LAST;
        end
      end
      PLOT: begin
        pending_n = pending || frame_start_in;
        if (last_px) begin
          state_n   = IDLE;
          start_clr = pending_n;
          pending_n = 1'b0;
        end else begin
          dx_n = sdx;
          dy_n = sdy;
          if (on_screen) begin
            we_n   = 1'b1;
            addr_n = pix_addr;
            data_n = pix_col;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (start_clr) begin
      state_n = CLEAR;
      drop_n  = 16'd0;
      we_n    = 1'b1;
      addr_n  = '0;
      data_n  = CLEAR_COLOR;
      done_n  = LAST == '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state             <= IDLE;
      px                <= '0;
      py                <= '0;
      pcol              <= '0;
      dx                <= '0;
      dy                <= '0;
      pending           <= 1'b0;
      fb_addr_out       <= '0;
      fb_data_out       <= '0;
      fb_we_out         <= 1'b0;
      clear_done_out    <= 1'b0;
      dropped_count_out <= '0;
    end else begin
      state             <= state_n;
      px                <= px_n;
      py                <= py_n;
      pcol              <= pcol_n;
      dx                <= dx_n;
      dy                <= dy_n;
      pending           <= pending_n;
      fb_addr_out       <= addr_n;
      fb_data_out       <= data_n;
      fb_we_out         <= we_n;
      clear_done_out    <= done_n;
      dropped_count_out <= drop_n;
    end
  end

endmodule

// File: tb/tb_particle_plotter.sv
// Directed bench for particle_plotter: clear sweep, sprite plotting,
// clipping, drops, pending frame start and asynchronous reset.
module tb_particle_plotter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs, valid, ready;
  logic [15:0] x, y, col;
  logic [15:0] addr, data, drop;
  logic        we, done;

  int vectors = 0;
  int miscompares = 0;

  particle_plotter dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .frame_start_in(fs),
    .valid_in(valid),
    .ready_out(ready),
    .x_in(x),
    .y_in(y),
    .color_in(col),
    .fb_addr_out(addr),
    .fb_data_out(data),
    .fb_we_out(we),
    .clear_done_out(done),
    .dropped_count_out(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input string tag, input logic [15:0] a,
                     input logic [15:0] d, input logic w);
    check({tag, "_we"}, 32'(we), 32'(w));
    if (w) begin
      check({tag, "_addr"}, 32'(addr), 32'(a));
      check({tag, "_data"}, 32'(data), 32'(d));
    end
    check({tag, "_rdy"}, 32'(ready), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    rst_n = 1'b0; fs = 1'b0; valid = 1'b0;
    x = '0; y = '0; col = '0;
    #1;
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_rdy", 32'(ready), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rel_rdy", 32'(ready), 32'd1);

    // full clear sweep
    fs = 1'b1;
    #1;
    check("fs_rdy", 32'(ready), 32'd0);
    tick();
    fs = 1'b0;
    bad = 0;
    for (int k = 0; k < 57600; k++) begin
      if (we !== 1'b1 || addr !== 16'(k) || data !== 16'h0000 ||
          done !== (k == 57599) || ready !== 1'b0)
        bad++;
      tick();
    end
    check("clr_sweep", 32'(bad), 32'd0);
    check("clr_end_we", 32'(we), 32'd0);
    check("clr_end_done", 32'(done), 32'd0);
    check("clr_end_rdy", 32'(ready), 32'd1);

    // on-screen sprite at (10,20)
    valid = 1'b1; x = 16'd10; y = 16'd20; col = 16'h001F;
    check("p1_acc_rdy", 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    pix("p1_0", 16'd6410, 16'h001F, 1'b1); tick();
    pix("p1_1", 16'd6411, 16'h001F, 1'b1); tick();
    pix("p1_2", 16'd6730, 16'h001F, 1'b1); tick();
    pix("p1_3", 16'd6731, 16'h001F, 1'b1); tick();
    check("p1_end_we", 32'(we), 32'd0);
    check("p1_end_rdy", 32'(ready), 32'd1);

    // corner sprite clipped to one pixel
    valid = 1'b1; x = 16'd319; y = 16'd179; col = 16'h07E0;
    tick();
    valid = 1'b0;
    pix("p2_0", 16'd57599, 16'h07E0, 1'b1); tick();
    pix("p2_1", 16'd0, 16'd0, 1'b0); tick();
    pix("p2_2", 16'd0, 16'd0, 1'b0); tick();
    pix("p2_3", 16'd0, 16'd0, 1'b0);
    check("p2_hold_addr", 32'(addr), 32'd57599);
    tick();
    check("p2_end_rdy", 32'(ready), 32'd1);

    // back-to-back drops
    valid = 1'b1; x = 16'd320; y = 16'd0;
    tick();
    check("d1_cnt", 32'(drop), 32'd1);
    check("d1_we", 32'(we), 32'd0);
    x = 16'd0; y = 16'd180;
    check("d1_rdy", 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    check("d2_cnt", 32'(drop), 32'd2);
    check("d2_we", 32'(we), 32'd0);
    check("d2_rdy", 32'(ready), 32'd1);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    check("d_fs_cnt", 32'(drop), 32'd0);
    check("d_fs_we", 32'(we), 32'd1);
    check("d_fs_addr", 32'(addr), 32'd0);

    // reset in the middle of a clear
    for (int k = 0; k < 1000; k++) tick();
    check("mid_addr", 32'(addr), 32'd1000);
    rst_n = 1'b0;
    #1;
    check("ar_addr", 32'(addr), 32'd0);
    check("ar_we", 32'(we), 32'd0);
    check("ar_drop", 32'(drop), 32'd0);
    check("ar_rdy", 32'(ready), 32'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (we !== 1'b0 || ready !== 1'b1) bad++;
    end
    check("ar_quiet", 32'(bad), 32'd0);

    // frame start pending during a sprite
    valid = 1'b1; x = 16'd0; y = 16'd0; col = 16'hF800;
    tick();
    valid = 1'b0;
    pix("pd_0", 16'd0, 16'hF800, 1'b1); tick();
    pix("pd_1", 16'd1, 16'hF800, 1'b1);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    pix("pd_2", 16'd320, 16'hF800, 1'b1); tick();
    pix("pd_3", 16'd321, 16'hF800, 1'b1); tick();
    pix("pd_c0", 16'd0, 16'h0000, 1'b1); tick();
    pix("pd_c1", 16'd1, 16'h0000, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("fv_idle_rdy", 32'(ready), 32'd1);

    // frame start beats a simultaneous particle
    fs = 1'b1; valid = 1'b1; x = 16'd5; y = 16'd5; col = 16'hFFFF;
    #1;
    check("fv_rdy", 32'(ready), 32'd0);
    tick();
    fs = 1'b0; valid = 1'b0;
    pix("fv_c0", 16'd0, 16'h0000, 1'b1);
    tick();
    pix("fv_c1", 16'd1, 16'h0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
